// File: rtl/rob_pkg.sv
`default_nettype none
// =============================================================================
// rob_pkg: instruction kinds, entry field widths and id-width helper for the ROB
// Rev 1.0
// =============================================================================
package rob_pkg;

  localparam int XLEN   = 32;
  localparam int RD_W   = 5;
  localparam int KIND_W = 2;

  typedef logic [KIND_W-1:0] kind_t;

  localparam kind_t K_REG  = 2'd0;
  localparam kind_t K_BR   = 2'd1;
  localparam kind_t K_ST   = 2'd2;
  localparam kind_t K_JALR = 2'd3;

  function automatic int id_width(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_query_port.sv
`default_nettype none
// =============================================================================
// rob_query_port: combinational operand lookup with writeback/issue bypass
// Rev 1.0
// =============================================================================
module rob_query_port
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ID_W  = id_width(DEPTH),
  parameter int WB_CH = 2
) (
  input  logic [ID_W-1:0]       qry_id_i,
  input  logic [DEPTH-1:0]      prep_i,
  input  logic [DEPTH*XLEN-1:0] value_i,
  input  logic [WB_CH-1:0]      wb_hit_i,   // already qualified by rdy and target busy
  input  logic [WB_CH*ID_W-1:0] wb_id_i,
  input  logic [WB_CH*XLEN-1:0] wb_value_i,
  input  logic                  iss_hit_i,
  input  logic [ID_W-1:0]       iss_id_i,
  input  logic [XLEN-1:0]       iss_value_i,
  output logic                  ready_o,
  output logic [XLEN-1:0]       value_o
);

  // Sources are applied lowest priority first so the last match wins.
  always_comb begin
    ready_o = 1'b0;
    value_o = '0;
    if (iss_hit_i && (qry_id_i == iss_id_i)) begin
      ready_o = 1'b1;
      value_o = iss_value_i;
    end
    for (int c = WB_CH - 1; c >= 0; c--) begin
      if (wb_hit_i[c] && (wb_id_i[c*ID_W +: ID_W] == qry_id_i)) begin
        ready_o = 1'b1;
        value_o = wb_value_i[c*XLEN +: XLEN];
      end
    end
    if (prep_i[qry_id_i]) begin
      ready_o = 1'b1;
      value_o = value_i[XLEN*qry_id_i +: XLEN];
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_param.sv
`default_nettype none
// =============================================================================
// rob_param: parameterised reorder buffer, WB_CH writeback channels, commit-time
// branch resolution with registered redirect. Rev 1.0
// =============================================================================
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int ID_W  = id_width(DEPTH),
  parameter int WB_CH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  output logic [ID_W-1:0]       issue_id,
  input  logic [KIND_W-1:0]     issue_kind,
  input  logic [RD_W-1:0]       issue_rd,
  input  logic [XLEN-1:0]       issue_pc,
  input  logic                  issue_pred_taken,
  input  logic [XLEN-1:0]       issue_value,
  input  logic                  issue_value_valid,
  input  logic [WB_CH-1:0]      wb_valid,
  input  logic [WB_CH*ID_W-1:0] wb_id,
  input  logic [WB_CH*XLEN-1:0] wb_value,
  input  logic [WB_CH-1:0]      wb_taken,
  input  logic [WB_CH*XLEN-1:0] wb_target,
  output logic                  commit_valid,
  output logic [ID_W-1:0]       commit_id,
  output logic [RD_W-1:0]       commit_rd,
  output logic [XLEN-1:0]       commit_value,
  output logic [ID_W-1:0]       head_id,
  input  logic [ID_W-1:0]       qry_id1,
  input  logic [ID_W-1:0]       qry_id2,
  output logic                  qry_ready1,
  output logic                  qry_ready2,
  output logic [XLEN-1:0]       qry_value1,
  output logic [XLEN-1:0]       qry_value2,
  output logic                  flush,
  output logic [XLEN-1:0]       flush_pc,
  output logic [ID_W:0]         count
);

  localparam logic [ID_W:0] FULL_CNT = (ID_W + 1)'(DEPTH);

  logic [DEPTH-1:0]      busy_q, prep_q, pred_q, taken_q;
  kind_t                 kind_q [DEPTH];
  logic [RD_W-1:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]       pc_q   [DEPTH];
  logic [XLEN-1:0]       tgt_q  [DEPTH];
  logic [DEPTH*XLEN-1:0] val_q;
  logic [ID_W-1:0]       head_q, tail_q, head_d, tail_d;
  logic [ID_W:0]         count_q, count_d;
  logic                  flush_q;
  logic [XLEN-1:0]       flush_pc_q;

  logic                  issue_fire, mispredict;
  logic [XLEN-1:0]       redirect_pc;
  logic [ID_W-1:0]       wb_idx [WB_CH];
  logic [WB_CH-1:0]      wb_hit;

  assign issue_ready  = (count_q != FULL_CNT) && !flush_q;
  assign issue_fire   = rdy && issue_valid && issue_ready;
  assign commit_valid = rdy && !flush_q && busy_q[head_q] && prep_q[head_q];
  assign mispredict   = commit_valid &&
                        ((kind_q[head_q] == K_JALR) ||
                         ((kind_q[head_q] == K_BR) && (taken_q[head_q] != pred_q[head_q])));
  assign redirect_pc  = ((kind_q[head_q] == K_JALR) || taken_q[head_q]) ? tgt_q[head_q]
                                                                          : pc_q[head_q] + 32'd4;

  assign issue_id     = tail_q;
  assign head_id      = head_q;
  assign commit_id    = head_q;
  assign commit_rd    = (commit_valid && (kind_q[head_q] != K_BR) && (kind_q[head_q] != K_ST))
                        ? rd_q[head_q] : '0;
  assign commit_value = commit_valid ? val_q[XLEN*head_q +: XLEN] : '0;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;
  assign count        = count_q;

  always_comb begin
    for (int c = 0; c < WB_CH; c++) begin
      wb_idx[c] = wb_id[c*ID_W +: ID_W];
      wb_hit[c] = rdy && wb_valid[c] && busy_q[wb_idx[c]];
    end
  end

  always_comb begin
    head_d  = commit_valid ? head_q + ID_W'(1) : head_q;
    tail_d  = issue_fire ? tail_q + ID_W'(1) : tail_q;
    count_d = count_q;
    if (issue_fire && !commit_valid) begin
      count_d = count_q + (ID_W + 1)'(1);
    end else if (!issue_fire && commit_valid) begin
      count_d = count_q - (ID_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q     <= '0;
      prep_q     <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      val_q      <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        kind_q[i] <= K_REG;
        rd_q[i]   <= '0;
        pc_q[i]   <= '0;
        tgt_q[i]  <= '0;
      end
    end else if (rdy) begin
      // Descending order lets channel 0 take precedence on a shared id.
      for (int c = WB_CH - 1; c >= 0; c--) begin
        if (wb_hit[c]) begin
          prep_q[wb_idx[c]]               <= 1'b1;
          val_q[XLEN*wb_idx[c] +: XLEN]   <= wb_value[c*XLEN +: XLEN];
          taken_q[wb_idx[c]]              <= wb_taken[c];
          tgt_q[wb_idx[c]]                <= wb_target[c*XLEN +: XLEN];
        end
      end
      flush_q <= mispredict;
      if (mispredict) begin
        busy_q     <= '0;
        prep_q     <= '0;
        head_q     <= '0;
        tail_q     <= '0;
        count_q    <= '0;
        flush_pc_q <= redirect_pc;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        if (commit_valid) begin
          busy_q[head_q] <= 1'b0;
          prep_q[head_q] <= 1'b0;
        end
        if (issue_fire) begin
          busy_q[tail_q]             <= 1'b1;
          prep_q[tail_q]             <= issue_value_valid;
          kind_q[tail_q]             <= issue_kind;
          rd_q[tail_q]               <= issue_rd;
          pc_q[tail_q]               <= issue_pc;
          pred_q[tail_q]             <= issue_pred_taken;
          val_q[XLEN*tail_q +: XLEN] <= issue_value;
          taken_q[tail_q]            <= 1'b0;
          tgt_q[tail_q]              <= '0;
        end
      end
    end
  end

  rob_query_port #(.DEPTH(DEPTH), .ID_W(ID_W), .WB_CH(WB_CH)) u_qry1 (
    .qry_id_i    (qry_id1),
    .prep_i      (prep_q),
    .value_i     (val_q),
    .wb_hit_i    (wb_hit),
    .wb_id_i     (wb_id),
    .wb_value_i  (wb_value),
    .iss_hit_i   (issue_fire && issue_value_valid),
    .iss_id_i    (tail_q),
    .iss_value_i (issue_value),
    .ready_o     (qry_ready1),
    .value_o     (qry_value1)
  );

  rob_query_port #(.DEPTH(DEPTH), .ID_W(ID_W), .WB_CH(WB_CH)) u_qry2 (
    .qry_id_i    (qry_id2),
    .prep_i      (prep_q),
    .value_i     (val_q),
    .wb_hit_i    (wb_hit),
    .wb_id_i     (wb_id),
    .wb_value_i  (wb_value),
    .iss_hit_i   (issue_fire && issue_value_valid),
    .iss_id_i    (tail_q),
    .iss_value_i (issue_value),
    .ready_o     (qry_ready2),
    .value_o     (qry_value2)
  );

endmodule
`default_nettype wire
